// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB instruction sequencer with memory handshakes.
// Optional SEQ_TIMEOUT_EN macro adds an ack-wait watchdog that traps into ERR.
module multicycle_sequencer #(
    parameter int XLEN        = 32,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic [XLEN-1:0]  instr,
    input  logic             dec_is_load,
    input  logic             dec_write_en,
    output logic             alu_en,
    output logic             dmem_req,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic             pc_inc,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             timeout_err
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, MEM = 3'd4, WB = 3'd5, ERR = 3'd6
    } state_t;

    state_t            state_q;
    logic [XLEN-1:0]   instr_q;
    logic [CNT_W-1:0]  retired_q;
    logic              ld_q, we_q;
    logic              imem_req_q, dmem_req_q, alu_en_q, rf_we_q, pc_inc_q;
    logic              retire_d;

    // NOP retires straight out of EXEC; everything else retires out of WB
    assign retire_d = (state_q == WB) || (state_q == EXEC && !ld_q && !we_q);

`ifdef SEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_q;
    logic              timeout_err_q;
    logic              waiting_d, wait_hit_d;
    assign waiting_d   = (state_q == FETCH && !imem_ack) || (state_q == MEM && !dmem_ack);
    assign wait_hit_d  = waiting_d && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            retired_q  <= '0;
            ld_q       <= 1'b0;
            we_q       <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            alu_en_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            pc_inc_q   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            wait_q        <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            alu_en_q <= 1'b0;
            rf_we_q  <= 1'b0;
            pc_inc_q <= 1'b0;
            case (state_q)
                IDLE: if (run) begin
                    state_q    <= FETCH;
                    imem_req_q <= 1'b1;
                end
                FETCH: if (imem_ack) begin
                    instr_q    <= imem_rdata;
                    imem_req_q <= 1'b0;
                    state_q    <= DECODE;
                end
                DECODE: begin
                    ld_q     <= dec_is_load;
                    we_q     <= dec_write_en;
                    alu_en_q <= 1'b1;
                    state_q  <= EXEC;
                end
                EXEC: if (ld_q) begin
                    dmem_req_q <= 1'b1;
                    state_q    <= MEM;
                end else if (we_q) begin
                    rf_we_q <= 1'b1;
                    state_q <= WB;
                end
                MEM: if (dmem_ack) begin
                    dmem_req_q <= 1'b0;
                    rf_we_q    <= we_q;
                    state_q    <= WB;
                end
                default: ;
            endcase
            if (retire_d) begin
                pc_inc_q   <= 1'b1;
                retired_q  <= retired_q + 1'b1;
                imem_req_q <= run;
                state_q    <= run ? FETCH : IDLE;
            end
`ifdef SEQ_TIMEOUT_EN
            wait_q <= waiting_d ? wait_q + 1'b1 : '0;
            if (wait_hit_d) begin
                imem_req_q    <= 1'b0;
                dmem_req_q    <= 1'b0;
                timeout_err_q <= 1'b1;
                state_q       <= ERR;
            end
`endif
        end
    end

    assign state    = state_q;
    assign instr    = instr_q;
    assign retired  = retired_q;
    assign imem_req = imem_req_q;
    assign dmem_req = dmem_req_q;
    assign alu_en   = alu_en_q;
    assign rf_we    = rf_we_q;
    assign pc_inc   = pc_inc_q;
endmodule
